escaner_teclado: RTL

Scans a 4x4 matrix keypad and produces a clean "key is down" level plus a 4-bit key code.
- Drives one column low at a time and samples the rows through a two-flop synchronizer.
- Once a key is found, freezes on that column until the key is released.
- Sits directly upstream of the edge-detect/debounce event stage: `tecla_presionada` feeds that stage's key-level input, and `codigo_tecla` is held stable for downstream decoding.

---
 rtl/teclado_pkg.sv | 25 ++
 rtl/sincronizador_2ff.sv | 27 ++
 rtl/escaner_teclado.sv | 112 +++++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package teclado_pkg;

  // Scanner FSM: 1-bit encoding, one state per phase.
  typedef enum logic {
    ESCANEO  = 1'b0,
    MANTENER = 1'b1
  } estado_t;

  localparam int unsigned SCAN_TICKS_DEF      = 12000;
  localparam int unsigned RELEASE_SAMPLES_DEF = 3;
  localparam int unsigned CODE_W              = 4;
  localparam int unsigned N_LINEAS            = 4;

  // Index of the lowest row that reads low (rows are active-low).
  function automatic logic [1:0] fila_mas_baja(input logic [N_LINEAS-1:0] f);
    logic [1:0] r;
    r = 2'd0;
    for (int i = N_LINEAS - 1; i >= 0; i--) begin
      if (!f[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read inactive.
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: walks one active-low column at a time, locks onto the first
// key found and holds until that row reads high for RELEASE_SAMPLES samples.
module escaner_teclado
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = SCAN_TICKS_DEF,
  parameter int unsigned RELEASE_SAMPLES = RELEASE_SAMPLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LINEAS-1:0] filas,
  output logic [N_LINEAS-1:0] columnas,
  output logic                tecla_presionada,
  output logic [CODE_W-1:0]   codigo_tecla
);

  localparam int unsigned CntW    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned SueltaW = (RELEASE_SAMPLES > 0) ? $clog2(RELEASE_SAMPLES + 1) : 1;
  localparam logic [CntW-1:0]    CntMax    = CntW'(SCAN_TICKS - 1);
  localparam logic [SueltaW-1:0] SueltaMax = SueltaW'(RELEASE_SAMPLES);

  logic [N_LINEAS-1:0] filas_s;
  estado_t             estado_q, estado_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          fila_q, fila_d;
  logic [SueltaW-1:0]  suelta_q, suelta_d;
  logic [CODE_W-1:0]   codigo_q, codigo_d;
  logic [N_LINEAS-1:0] columnas_q, columnas_d;
  logic                tecla_q, tecla_d;
  logic                muestra;

  sincronizador_2ff #(
    .WIDTH(N_LINEAS)
  ) u_sinc_filas (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (filas),
    .q_o  (filas_s)
  );

  assign muestra = (cnt_q == CntMax);

  // Next-state: dwell counter, scan/hold FSM, release counter and output values.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = muestra ? '0 : cnt_q + 1'b1;
    col_d    = col_q;
    fila_d   = fila_q;
    suelta_d = suelta_q;
    codigo_d = codigo_q;
    if (muestra) begin
      unique case (estado_q)
        ESCANEO: begin
          if (!(&filas_s)) begin
            // Column stays put so the held key keeps pulling its row low.
            fila_d   = fila_mas_baja(filas_s);
            codigo_d = {fila_d, col_q};
            estado_d = MANTENER;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        MANTENER: begin
          // Only the locked row matters; a low sample restarts the release count.
          if (filas_s[fila_q]) begin
            if (suelta_q + 1'b1 == SueltaMax) begin
              estado_d = ESCANEO;
              suelta_d = '0;
              col_d    = col_q + 2'd1;
            end else begin
              suelta_d = suelta_q + 1'b1;
            end
          end else begin
            suelta_d = '0;
          end
        end
        default: estado_d = ESCANEO;
      endcase
    end
    columnas_d = ~(4'b0001 << col_d);
    tecla_d    = (estado_d == MANTENER);
  end

  // State and output registers; asynchronous reset to the idle scan of column 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= ESCANEO;
      cnt_q      <= '0;
      col_q      <= 2'd0;
      fila_q     <= 2'd0;
      suelta_q   <= '0;
      codigo_q   <= '0;
      columnas_q <= 4'b1110;
      tecla_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      fila_q     <= fila_d;
      suelta_q   <= suelta_d;
      codigo_q   <= codigo_d;
      columnas_q <= columnas_d;
      tecla_q    <= tecla_d;
    end
  end

  assign columnas         = columnas_q;
  assign tecla_presionada = tecla_q;
  assign codigo_tecla     = codigo_q;

endmodule
